// File: rtl/command_fifo_mc_pkg.sv
// Shared sizing helpers and the output command bundle
// for the multi-channel command FIFO.
package command_fifo_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int chan_bits(input int chans);
    return (chans > 2) ? $clog2(chans) : 1;
  endfunction

  localparam int CMD_WIDTH = 16;
  localparam int CMD_CHAN_BITS = chan_bits(4);

  typedef struct packed {
    logic [CMD_WIDTH-1:0]     data;
    logic [CMD_CHAN_BITS-1:0] chan;
  } cmd_out_t;

endpackage

// File: rtl/command_fifo_mc_if.sv
// Producer-side write/status bus and consumer-side
// valid/ready stream of the multi-channel command FIFO.
interface command_fifo_mc_if
  import command_fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 4
) ();
  localparam int CW  = count_width(DEPTH);
  localparam int CHB = chan_bits(CHANNELS);

  logic [CHANNELS-1:0]       wr_en;
  logic [CHANNELS*WIDTH-1:0] wr_data;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       almost_full;
  logic [CHANNELS*CW-1:0]    count;
  logic [CHANNELS-1:0]       overflow;
  logic                      clr_overflow;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CHB-1:0]            out_chan;

  modport master (
    output wr_en, wr_data, clr_overflow,
    output out_ready,
    input  full, almost_full, count,
    input  overflow, out_valid,
    input  out_data, out_chan
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    input  out_ready,
    output full, almost_full, count,
    output overflow, out_valid,
    output out_data, out_chan
  );
endinterface

// File: rtl/command_fifo_mc_ch.sv
// One command queue: full-depth circular buffer with
// an extra pointer bit, registered status, sticky overflow.
module command_fifo_ch
  import command_fifo_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CW = count_width(DEPTH),
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_ovf_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             afull_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             wr_ok, rd_ok;

  // A full queue drops the write even when popped this cycle
  assign wr_ok = push_i && !full_q;
  assign rd_ok = pop_i && (cnt_q != '0);

  always_comb begin
    wptr_d  = wptr_q + PW'(wr_ok);
    rptr_d  = rptr_q + PW'(rd_ok);
    cnt_d   = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    full_d  = (cnt_d == CW'(DEPTH));
    afull_d = (cnt_d >= CW'(AFULL_THRESH));
    ovf_d   = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (push_i && full_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign count_o = cnt_q;
  assign full_o  = full_q;
  assign afull_o = afull_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/command_fifo_mc.sv
// CHANNELS command queues drained round-robin into one
// registered valid/ready stream tagged with the source channel.
module command_fifo_mc
  import command_fifo_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 16,
  parameter int CHANNELS     = 4,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CW  = count_width(DEPTH),
  localparam int CHB = chan_bits(CHANNELS)
) (
  input logic              clk,
  input logic              rst_n,
  command_fifo_mc_if.slave bus
);
  logic [WIDTH-1:0]    head [CHANNELS];
  logic [CW-1:0]       cnt  [CHANNELS];
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] nonempty;
  logic                load;
  logic                found;
  logic [CHB-1:0]      gnt;
  logic [CHB-1:0]      idx;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CHB-1:0]      chan_q, chan_d;
  logic [CHB-1:0]      last_q, last_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    command_fifo_ch #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_THRESH(AFULL_THRESH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (bus.wr_en[c]),
      .pop_i    (pop[c]),
      .clr_ovf_i(bus.clr_overflow),
      .din_i    (bus.wr_data[c*WIDTH +: WIDTH]),
      .head_o   (head[c]),
      .count_o  (cnt[c]),
      .full_o   (bus.full[c]),
      .afull_o  (bus.almost_full[c]),
      .ovf_o    (bus.overflow[c])
    );
    assign bus.count[c*CW +: CW] = cnt[c];
    assign nonempty[c] = (cnt[c] != '0);
    assign pop[c] = load && found && (gnt == CHB'(c));
  end

  assign load = !valid_q || bus.out_ready;

  // Search upward from the channel after the last grant
  always_comb begin
    found = 1'b0;
    gnt   = last_q;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CHB'((int'(last_q) + i) % CHANNELS);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        data_d  = head[gnt];
        chan_d  = gnt;
        last_d  = gnt;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= CHB'(CHANNELS - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_command_fifo_mc.sv
// Randomized bench for command_fifo_mc: queue-level reference
// model plus a scoreboard on the output stream.
module tb_command_fifo_mc;
  import command_fifo_pkg::*;

  localparam int W   = 16;
  localparam int D   = 16;
  localparam int CH  = 4;
  localparam int AF  = D - 2;
  localparam int CW  = count_width(D);
  localparam int CHB = chan_bits(CH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  command_fifo_mc_if #(
    .WIDTH(W), .DEPTH(D), .CHANNELS(CH)
  ) bus ();

  command_fifo_mc #(
    .WIDTH(W), .DEPTH(D), .CHANNELS(CH),
    .AFULL_THRESH(AF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CHB-1:0] chan;
    logic [W-1:0]   data;
  } exp_t;

  exp_t           expq[$];
  exp_t           mon_e;
  exp_t           new_e;
  logic [W-1:0]   mq [CH][$];
  logic [CH-1:0]  movf;
  bit             mvalid;
  logic [W-1:0]   mdata;
  logic [CHB-1:0] mchan;
  int             mlast;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    movf   = '0;
    mvalid = 1'b0;
    mdata  = '0;
    mchan  = '0;
    mlast  = CH - 1;
    expq.delete();
  endfunction

  function automatic bit model_busy();
    bit b = mvalid;
    for (int c = 0; c < CH; c++)
      if (mq[c].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic check_status();
    logic [CH*CW-1:0] ec;
    logic [CH-1:0]    ef;
    logic [CH-1:0]    ea;
    for (int c = 0; c < CH; c++) begin
      ec[c*CW +: CW] = CW'(mq[c].size());
      ef[c] = (mq[c].size() == D);
      ea[c] = (mq[c].size() >= AF);
    end
    check("count", 64'(bus.count), 64'(ec));
    check("full", 64'(bus.full), 64'(ef));
    check("almost_full", 64'(bus.almost_full), 64'(ea));
    check("overflow", 64'(bus.overflow), 64'(movf));
    check("out_valid", 64'(bus.out_valid), 64'(mvalid));
    if (mvalid) begin
      check("out_data", 64'(bus.out_data), 64'(mdata));
      check("out_chan", 64'(bus.out_chan), 64'(mchan));
    end
  endtask

  // Predict what the coming rising edge does, at queue level
  task automatic model_step();
    int sz [CH];
    bit found;
    int g;
    int c;
    for (int k = 0; k < CH; k++) sz[k] = mq[k].size();
    if (!mvalid || bus.out_ready) begin
      found = 1'b0;
      g = 0;
      for (int i = 1; i <= CH; i++) begin
        c = (mlast + i) % CH;
        if (!found && sz[c] > 0) begin
          found = 1'b1;
          g = c;
        end
      end
      if (found) begin
        mdata  = mq[g].pop_front();
        mchan  = CHB'(g);
        mvalid = 1'b1;
        mlast  = g;
        new_e.chan = CHB'(g);
        new_e.data = mdata;
        expq.push_back(new_e);
      end else begin
        mvalid = 1'b0;
      end
    end
    if (bus.clr_overflow) movf = '0;
    for (int k = 0; k < CH; k++) begin
      if (bus.wr_en[k]) begin
        if (sz[k] == D) movf[k] = 1'b1;
        else mq[k].push_back(bus.wr_data[k*W +: W]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_full", 64'(bus.full), 64'd0);
      check("rst_afull", 64'(bus.almost_full), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data", 64'(bus.out_data), 64'd0);
      check("rst_chan", 64'(bus.out_chan), 64'd0);
    end else begin
      check_status();
      model_step();
    end
  end

  // Scoreboard monitor: one pop per accepted transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got chan %0d data %0h expected none",
                 bus.out_chan, bus.out_data);
      end else begin
        mon_e = expq.pop_front();
        check("sb_data", 64'(bus.out_data), 64'(mon_e.data));
        check("sb_chan", 64'(bus.out_chan), 64'(mon_e.chan));
      end
    end
  end

  function automatic logic [CH*W-1:0] rnd();
    logic [CH*W-1:0] d;
    for (int c = 0; c < CH; c++) d[c*W +: W] = W'($urandom);
    return d;
  endfunction

  function automatic logic [CH*W-1:0] rr_data(input int k);
    logic [CH*W-1:0] d;
    for (int c = 0; c < CH; c++)
      d[c*W +: W] = W'(32'hC000 | (c << 4) | k);
    return d;
  endfunction

  task automatic cyc(input logic [CH-1:0] we,
                     input logic [CH*W-1:0] d,
                     input logic rdy,
                     input logic clr);
    @(posedge clk);
    #1;
    bus.wr_en        = we;
    bus.wr_data      = d;
    bus.out_ready    = rdy;
    bus.clr_overflow = clr;
  endtask

  task automatic drain();
    int n = 0;
    cyc('0, '0, 1'b1, 1'b0);
    while (model_busy() && n < 200) begin
      cyc('0, '0, 1'b1, 1'b0);
      n++;
    end
    cyc('0, '0, 1'b1, 1'b0);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain: busy after %0d cycles expected empty", n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    bus.wr_en        = '0;
    bus.wr_data      = '0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CH-1:0] we;
    bus.wr_en        = '0;
    bus.wr_data      = '0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill channel 2 past full with the consumer stalled
    for (int k = 0; k < 18; k++) cyc(4'b0100, rnd(), 1'b0, 1'b0);
    cyc(4'b0100, rnd(), 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b0);
    drain();

    // round robin over two words per channel
    cyc(4'hF, rr_data(0), 1'b0, 1'b0);
    cyc(4'hF, rr_data(1), 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    repeat (10) cyc('0, '0, 1'b1, 1'b0);

    // backpressure
    cyc(4'b1011, rnd(), 1'b0, 1'b0);
    cyc(4'b1011, rnd(), 1'b0, 1'b0);
    repeat (5) cyc('0, '0, 1'b0, 1'b0);
    repeat (8) cyc('0, '0, 1'b1, 1'b0);

    // ch1 at count 3, write and grant together
    for (int k = 0; k < 4; k++) cyc(4'b0010, rnd(), 1'b0, 1'b0);
    cyc(4'b0010, rnd(), 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    drain();

    // ch1 full, write and pop together
    for (int k = 0; k < 17; k++) cyc(4'b0010, rnd(), 1'b0, 1'b0);
    cyc(4'b0010, rnd(), 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b1);
    drain();

    // pointer wrap on ch0
    for (int k = 0; k < 40; k++)
      cyc(4'b0001, rnd(), 1'(($urandom % 4) != 0), 1'b0);
    drain();

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      we = (k < 750) ? CH'($urandom)
                     : CH'($urandom & $urandom);
      cyc(we, rnd(), 1'(($urandom % 3) != 0),
          1'(($urandom % 50) == 0));
    end
    drain();

    // reset with queued and in-flight data
    for (int k = 0; k < 6; k++) cyc(4'hF, rnd(), 1'b0, 1'b0);
    do_reset();
    repeat (4) cyc('0, '0, 1'b1, 1'b0);
    cyc(4'b1000, rnd(), 1'b1, 1'b0);
    cyc(4'b0001, rnd(), 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
